// File: rtl/class_score_sched.sv
// Clause-weight read sequencer: walks classes x clauses, sums firing-clause
// weights per class and tracks the arg-max class and its score.
module class_score_sched #(
   parameter int CLAUSEN = 10,
   parameter int CLASSN  = 10,
   parameter int RD_LAT  = 2,
   parameter int SUMW    = 18
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [CLAUSEN-1:0]         clause_out,
   input  logic signed [8:0]          weight,
   output logic [$clog2(CLASSN)-1:0]  bram_addr_2,
   output logic [$clog2(CLAUSEN)-1:0] clauses,
   output logic [$clog2(CLAUSEN)-1:0] clause_no,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(CLASSN)-1:0]  class_pred,
   output logic signed [SUMW-1:0]     max_sum
);

   localparam int CW = $clog2(CLAUSEN);
   localparam int AW = $clog2(CLASSN);
   localparam int DW = $clog2(RD_LAT + 1);
   localparam logic signed [SUMW-1:0] SUM_MIN = {1'b1, {(SUMW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CMP, DONE} state_t;

   state_t state, state_nx;

   logic [CLAUSEN-1:0]     clause_reg;
   logic signed [SUMW-1:0] acc;
   logic [DW-1:0]          dcnt;
   logic                   tag_v [RD_LAT];
   logic                   tag_f [RD_LAT];
   logic                   last_clause;
   logic                   last_drain;
   logic                   last_class;
   logic signed [SUMW-1:0] wext;

   assign clauses     = CW'(CLAUSEN);
   assign last_clause = (clause_no == CW'(CLAUSEN - 1));
   assign last_drain  = (dcnt == DW'(RD_LAT - 1));
   assign last_class  = (bram_addr_2 == AW'(CLASSN - 1));
   assign wext        = {{(SUMW-9){weight[8]}}, weight};
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start) state_nx = ISSUE;
         ISSUE: if (last_clause) state_nx = DRAIN;
         DRAIN: if (last_drain) state_nx = CMP;
         CMP:   state_nx = last_class ? DONE : ISSUE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clause_reg  <= '0;
         acc         <= '0;
         dcnt        <= '0;
         bram_addr_2 <= '0;
         clause_no   <= '0;
         class_pred  <= '0;
         max_sum     <= SUM_MIN;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_v[i] <= 1'b0;
            tag_f[i] <= 1'b0;
         end
      end else begin
         // Tag pipe mirrors the read latency so each weight meets its fire bit.
         tag_v[0] <= (state == ISSUE);
         tag_f[0] <= (state == ISSUE) && clause_reg[clause_no];
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_f[i] <= tag_f[i-1];
         end
         if (tag_v[RD_LAT-1] && tag_f[RD_LAT-1])
            acc <= acc + wext;

         unique case (state)
            IDLE: begin
               if (start) begin
                  clause_reg  <= clause_out;
                  acc         <= '0;
                  bram_addr_2 <= '0;
                  clause_no   <= '0;
                  class_pred  <= '0;
                  max_sum     <= SUM_MIN;
               end
            end
            ISSUE: begin
               clause_no <= last_clause ? '0 : clause_no + CW'(1);
               dcnt      <= '0;
            end
            DRAIN: dcnt <= dcnt + DW'(1);
            CMP: begin
               if (acc > max_sum) begin
                  max_sum    <= acc;
                  class_pred <= bram_addr_2;
               end
               acc <= '0;
               if (!last_class) bram_addr_2 <= bram_addr_2 + AW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/class_score_sched.md
# class_score_sched

Sequencing controller for the clause-weight read path in the RConvCoTM inference datapath. On `start` it latches the clause output vector, then walks every class and every clause, driving the row address and clause index into the `weight_adder` block. For each class it accumulates the signed weights of the firing clauses into a class sum and keeps a running arg-max. When all classes are scored it reports the predicted class and its score with a one-cycle `done` pulse.

## Interface
- `CLAUSEN`, 10: clauses per class; one 9-bit weight per clause in each weight-memory row.
- `CLASSN`, 10: number of classes, equal to the number of weight-memory rows.
- `RD_LAT`, 2: cycles from `bram_addr_2`/`clause_no` change to the matching `weight` value (BRAM read plus output register).
- `SUMW`, 18: class-sum width. Must satisfy `SUMW >= 9 + $clog2(CLAUSEN) + 1`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a scoring pass; sampled only in IDLE.
- `clause_out`  in  CLAUSEN  clause firing vector; bit i = clause i fired. Latched when `start` is accepted.
- `weight`  in  9  signed two's-complement weight from `weight_adder`.
- `bram_addr_2`  out  $clog2(CLASSN)  weight-memory read row, equal to the current class index.
- `clauses`  out  $clog2(CLAUSEN)  constant `CLAUSEN`; sets clause count for weight slicing.
- `clause_no`  out  $clog2(CLAUSEN)  clause index being read.
- `busy`  out  1  high from start acceptance until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle.
- `class_pred`  out  $clog2(CLASSN)  arg-max class index.
- `max_sum`  out  SUMW  signed score of `class_pred`.

## Operation
- Reset values: state IDLE; `bram_addr_2`=0, `clause_no`=0, `busy`=0, `done`=0, `class_pred`=0, `max_sum`=-2^(SUMW-1); accumulator, class counter and valid pipe cleared.
- **IDLE**
  - `start`=1 latches `clause_out` into `clause_reg`.
  - Clears the accumulator, sets the class index to 0 and `max_sum` to -2^(SUMW-1).
  - Moves to ISSUE.
- **ISSUE** (CLAUSEN cycles per class)
  - Drives `clause_no` = 0..CLAUSEN-1, one per cycle, with `bram_addr_2` = class index.
  - Each issue pushes {valid=1, fire=`clause_reg[clause_no]`} into an RD_LAT-deep tag pipe.
  - After the last clause, moves to DRAIN.
- **DRAIN** (RD_LAT cycles)
  - No new issues; the tag pipe empties.
  - Then moves to CMP.
- **Accumulate** (any state)
  - When a tag exits the pipe with valid=1 and fire=1: `acc += sext(weight)`, with `weight` sign-extended from bit 8 to SUMW.
  - fire=0 adds nothing. No saturation is required under the SUMW rule.
- **CMP** (1 cycle)
  - If `acc > max_sum` (signed, strict): `max_sum <= acc`, `class_pred <=` class index. Ties keep the lower class index.
  - Clears `acc`.
  - If the class index is CLASSN-1, moves to DONE. Otherwise increments the class index and moves to ISSUE.
- **DONE** (1 cycle)
  - `done`=1, `busy`=1; then moves to IDLE.
  - `class_pred`/`max_sum` hold until the next accepted `start`.
- `start` outside IDLE is ignored. Changes to `clause_out` after acceptance have no effect.
- `rst` asserted mid-pass: all reset values apply immediately, no `done` pulse, partial results discarded.

## Timing
- `start` sampled high at edge 0: ISSUE for class 0 occupies cycles 1..CLAUSEN.
- Each class takes CLAUSEN + RD_LAT + 1 cycles.
- `done` is high in cycle CLASSN*(CLAUSEN+RD_LAT+1)+1. With defaults, that is cycle 131.
- `weight` is sampled exactly RD_LAT cycles after the matching `clause_no` is driven. The bench model must present weights with that latency.
- `start` in the `done` cycle is ignored; the earliest restart is the following cycle, back in IDLE.

## Test plan
- Defaults, all clauses fire, row c has every weight = c-5: sums are 10*(c-5). Require `class_pred`=9, `max_sum`=40, `done` in cycle 131.
- All weights = -256 (0x100), all clauses fire: every sum is -2560. Require `class_pred`=0 (tie rule), `max_sum`=-2560.
- `clause_out`=0: all sums are 0. Require `class_pred`=0, `max_sum`=0.
- `clause_out`=10'b0000000001, so only clause 0 fires. Row 3 clause 0 weight = +255, all other weights 0. Toggle `clause_out` mid-pass. Require `class_pred`=3, `max_sum`=255, and the toggle has no effect.
- `start` pulsed again at cycles 5 and 131: both ignored, exactly one `done`, `busy` continuously high cycles 1..131.
- `rst` low at cycle 40, `start` again at cycle 50: no `done` before cycle 181; outputs at reset values during 40..50; the second pass result is correct.
